// File: rtl/bitwise_issue_pkg.sv
// Shared definitions for the bitwise issue stage: FSM state encoding and
// opcode constants understood by the external bitwise unit.
package bitwise_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcode bits [1:0] select the function; the top opcode bit is the operand flag.
    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_COMP = 2'd3;

    localparam int OPND_FLAG_POS = 2;

endpackage

// File: rtl/bitwise_issue.sv
// Issue stage for an external combinational bitwise unit: registers a command
// onto the unit, captures its result one cycle later, and holds it until taken.
module bitwise_issue
    import bitwise_issue_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int INST_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [INST_WIDTH-1:0] cmd_op,
    input  logic [BUS_WIDTH-1:0]  cmd_a,
    input  logic [BUS_WIDTH-1:0]  cmd_b,
    output logic [BUS_WIDTH-1:0]  alu_a,
    output logic [BUS_WIDTH-1:0]  alu_b,
    output logic [INST_WIDTH-1:0] alu_inst,
    input  logic [BUS_WIDTH-1:0]  alu_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_WIDTH-1:0]  rsp_data,
    output logic [INST_WIDTH-1:0] rsp_op,
    output logic                  rsp_zero,
    output logic [7:0]            op_count
);

    state_t state, state_nxt;
    logic   cmd_fire;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_zero  = (rsp_data == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP: begin
                // A new command may overlap the handshake, giving one result every two cycles.
                cmd_ready = rsp_ready;
                if (rsp_ready) state_nxt = cmd_valid ? ST_ISSUE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand registers keep their last command outside ISSUE rather than clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_inst <= '0;
        end else if (cmd_fire) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_inst <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_op   <= '0;
        end else if (state == ST_ISSUE) begin
            rsp_data <= alu_y;
            rsp_op   <= alu_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'd0;
        end else if (rsp_valid && rsp_ready && (op_count != 8'hFF)) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: doc/bitwise_issue.md
BITWISE_ISSUE -- requirements
Module: bitwise_issue

Interface
REQ-001 Parameter BUS_WIDTH, default 8, SHALL set the operand and result width.
REQ-002 Parameter INST_WIDTH, default 3, SHALL set the opcode width; bit INST_WIDTH-1 is the operand flag and bits [1:0] select AND/OR/XOR/complement.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the ports below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block can accept a command this cycle.
REQ-008 cmd_op  in  INST_WIDTH  opcode.
REQ-009 cmd_a, cmd_b  in  BUS_WIDTH each  operands.
REQ-010 alu_a, alu_b  out  BUS_WIDTH each  operands driven to the bitwise unit.
REQ-011 alu_inst  out  INST_WIDTH  opcode driven to the bitwise unit.
REQ-012 alu_y  in  BUS_WIDTH  combinational result returned by the bitwise unit.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer takes the result.
REQ-015 rsp_data  out  BUS_WIDTH  captured result.
REQ-016 rsp_op  out  INST_WIDTH  opcode that produced rsp_data.
REQ-017 rsp_zero  out  1  high when rsp_data is all zeros.
REQ-018 op_count  out  8  number of completed responses, saturating.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-020 A command transfers on a rising edge where cmd_valid and cmd_ready are both high.
REQ-021 cmd_ready SHALL be high in IDLE, high in RESP only while rsp_ready is high, and low in ISSUE.
REQ-022 On a transfer, cmd_a, cmd_b and cmd_op SHALL be registered onto alu_a, alu_b and alu_inst, and the FSM SHALL enter ISSUE.
REQ-023 In ISSUE, alu_y SHALL be captured at the next edge into rsp_data, with rsp_op = alu_inst and rsp_zero = (alu_y == 0); the FSM SHALL then enter RESP.
REQ-024 Latency: if a transfer happens at edge E, rsp_valid and rsp_data SHALL be valid after edge E+1.
REQ-025 rsp_valid SHALL be high only in RESP.
REQ-026 rsp_data, rsp_op and rsp_zero SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-027 RESP with rsp_ready high and no new transfer SHALL go to IDLE.
REQ-028 RESP with rsp_ready high and a simultaneous new transfer SHALL go directly to ISSUE, with no bubble; sustained throughput is one result per 2 cycles.
REQ-029 op_count SHALL increment on each edge where rsp_valid and rsp_ready are both high, and hold at 255.
REQ-030 alu_a, alu_b and alu_inst SHALL hold their last values outside ISSUE; they are not zeroed.
REQ-031 cmd_valid while cmd_ready is low SHALL have no effect; the producer holds the command.

Reset
REQ-032 While rst_n is low, the FSM SHALL be in IDLE and every register output SHALL be 0: alu_a, alu_b, alu_inst, rsp_data, rsp_op, rsp_valid, op_count.
REQ-033 While rst_n is low, cmd_ready SHALL be high and rsp_zero SHALL be 1, since it is derived from rsp_data = 0.
REQ-034 Reset asserted mid-operation in ISSUE or RESP SHALL discard the pending result without ever raising rsp_valid.

Structure
REQ-035 The state encoding (IDLE, ISSUE, RESP) and the opcode constants (AND=0, OR=1, XOR=2, COMP=3, operand-flag bit position) SHALL live in a shared bitwise package.
REQ-036 The block SHALL be one module with no sub-module; the bitwise unit is instantiated next to it at the level above, not inside it.

Verification
REQ-037 Single op: a=0xF0, b=0x3C, op=0 accepted at E -> alu_a=0xF0, alu_b=0x3C, alu_inst=0 after E; rsp_data=0x30 and rsp_valid=1 after E+1.
REQ-038 Back-pressure: XOR 0xAA^0xAA with rsp_ready=0 for 5 cycles -> rsp_data=0x00, rsp_zero=1 held stable; cmd_ready=0; op_count unchanged until rsp_ready=1, then 1.
REQ-039 Back-to-back: 4 commands with cmd_valid and rsp_ready always high -> results on alternate cycles; RESP->ISSUE with no IDLE; op_count=4.
REQ-040 Saturation: 260 completed ops -> op_count=255.
REQ-041 Reset mid-op: rst_n low during ISSUE -> all outputs 0 immediately, cmd_ready=1, rsp_valid never pulses; a later command completes normally.
